gate_tester: RTL
================

GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 SHALL have parameter GATE_OP, default 0, expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; values 6-7 behave as AND.
REQ-002 SHALL have parameter SETTLE, default 1, extra cycles each vector is held before sampling; legal range 0..15.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request one exhaustive test run; sampled only in IDLE.
REQ-007 dut_a  output  1  registered stimulus to gate input a.
REQ-008 dut_b  output  1  registered stimulus to gate input b.
REQ-009 dut_c  input  1  gate response under test.
REQ-010 busy  output  1  high while in DRIVE.
REQ-011 done  output  1  one-cycle pulse at end of run.
REQ-012 pass  output  1  run finished with zero mismatches.
REQ-013 err_cnt  output  3  mismatch count of current or last run, 0..4.
REQ-014 fail_vec  output  2  {a,b} of first mismatching vector (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, DRIVE and DONE.
REQ-016 IDLE with start=1 at an edge: go to DRIVE, dut_a/dut_b=0/0, hold counter=SETTLE, err_cnt=0, pass=0.
REQ-017 Vector order SHALL be index 0,1,2,3 with dut_a=index[1] and dut_b=index[0], i.e. 00, 01, 10, 11.
REQ-018 In DRIVE with hold counter nonzero: decrement only; outputs unchanged.
REQ-019 In DRIVE with hold counter zero: sample dut_c at that edge and compare to GATE_OP(dut_a,dut_b); on mismatch err_cnt+1 (saturating at 4).
REQ-020 At the same edge: index<3 -> next index, counter=SETTLE; index=3 -> go to DONE.
REQ-021 Each vector SHALL be held exactly SETTLE+1 cycles; DONE entered 4*(SETTLE+1) edges after the start edge.
REQ-022 DONE SHALL last one cycle with done=1, then go to IDLE; pass=1 from DONE entry if the final err_cnt is 0.
REQ-023 pass, err_cnt and fail_vec SHALL hold in IDLE until the next accepted start.
REQ-024 start in DRIVE or DONE SHALL be ignored with no effect on counters or results.
REQ-025 dut_a/dut_b SHALL return to 0/0 on entering DONE.
REQ-026 The final vector's comparison SHALL be included in pass and err_cnt at DONE entry.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=00, index=0 and hold counter=0.
REQ-028 Reset mid-run SHALL abandon the run without a done pulse; the next start restarts at vector 00.

Configuration
REQ-029 Macro GATE_TESTER_FAIL_CAPTURE_EN defined: fail_vec captures {dut_a,dut_b} at the first mismatch of a run; later mismatches leave it unchanged; cleared on accepted start.
REQ-030 Macro not defined: capture logic SHALL be absent and fail_vec tied to 00; all other behaviour identical.

Verification
REQ-031 GATE_OP=0, SETTLE=1, bench AND model, start pulse -> vectors 00,01,10,11 each held 2 cycles; done 8 edges after start; pass=1, err_cnt=0.
REQ-032 GATE_OP=0, dut_c tied 1 -> err_cnt=3, pass=0, fail_vec=00 (macro on) or 00 tied (macro off).
REQ-033 GATE_OP=2, bench OR model -> err_cnt=1, pass=0, fail_vec=11 (macro on).
REQ-034 SETTLE=0, start held high -> each vector held 1 cycle; done every 6 cycles (4 DRIVE + DONE + IDLE); start pulses while busy=1 are ignored.
REQ-035 rst pulsed asynchronously while dut_a/dut_b=1/0 -> outputs 0 before the next edge, no done pulse; next start runs from 00 with err_cnt=0.

Source files
------------

// File: rtl/gate_tester.sv
// Exhaustive two-input gate tester: drives 00,01,10,11, compares the response to GATE_OP.
// Define GATE_TESTER_FAIL_CAPTURE_EN to record the first failing {a,b} on fail_vec.
module gate_tester #(
  parameter int unsigned GATE_OP = 0,
  parameter int unsigned SETTLE  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic       mismatch;
  logic [2:0] err_inc;
  logic [1:0] idx_nxt;

  function automatic logic gate_ref(input logic a, input logic b);
    case (GATE_OP)
      1:       gate_ref = a | b;
      2:       gate_ref = a ^ b;
      3:       gate_ref = ~(a & b);
      4:       gate_ref = ~(a | b);
      5:       gate_ref = ~(a ^ b);
      default: gate_ref = a & b;
    endcase
  endfunction

  assign mismatch = (dut_c != gate_ref(a_q, b_q));
  assign err_inc  = (err_q == 3'd4) ? 3'd4 : err_q + 3'd1;
  assign idx_nxt  = idx_q + 2'd1;

`ifdef GATE_TESTER_FAIL_CAPTURE_EN
  logic [1:0] fv_q, fv_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
    fv_d    = fv_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          cnt_d   = SETTLE_C;
          a_d     = 1'b0;
          b_d     = 1'b0;
          err_d   = 3'd0;
          pass_d  = 1'b0;
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
          fv_d    = 2'b00;
`endif
        end
      end
      DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (mismatch) begin
            err_d = err_inc;
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
            // Only the first mismatch of a run is kept.
            if (err_q == 3'd0) fv_d = {a_q, b_q};
`endif
          end
          if (idx_q != 2'd3) begin
            idx_d = idx_nxt;
            a_d   = idx_nxt[1];
            b_d   = idx_nxt[0];
            cnt_d = SETTLE_C;
          end else begin
            state_d = DONE;
            idx_d   = 2'd0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = (err_d == 3'd0);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

`ifdef GATE_TESTER_FAIL_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fv_q <= 2'b00;
    else     fv_q <= fv_d;
  end
  assign fail_vec = fv_q;
`else
  assign fail_vec = 2'b00;
`endif

  assign dut_a   = a_q;
  assign dut_b   = b_q;
  assign busy    = (state_q == DRIVE);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule
